// File: rtl/line_buf_pkg.sv
// -----------------------------------------------------------------------------
// line_buf_pkg
// Shared definitions for the line buffer controller slice.
//   - state_t : controller state encoding (IDLE/FILL/DRAIN/FLUSH)
//   - DEF_*   : default geometry of the line buffer memory
// -----------------------------------------------------------------------------
package line_buf_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 16;

    // Number of words the output skid buffer can hold.  Reads are only issued
    // when the words already owed to downstream fit into this many slots.
    localparam int SKID_SLOTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/line_buf_skid.sv
// -----------------------------------------------------------------------------
// line_buf_skid
// Two-entry FIFO that catches words returning from the memory's registered
// read port, so the read pipeline can keep running while downstream stalls.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (clears entries and count)
//   push       in   write push_data into the tail slot
//   push_data  in   DATA_W word to store
//   pop        in   drop the head slot (only while count != 0)
//   head_data  out  DATA_W word at the head; stable until popped
//   count      out  number of occupied slots (0..2)
//
// The caller never pushes into a full buffer unless it pops in the same
// cycle; a simultaneous push and pop leaves the occupancy unchanged.
// -----------------------------------------------------------------------------
module line_buf_skid
    import line_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic       wr_idx_reg;
    logic       rd_idx_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;

    // One storage register per slot; the slot written is selected by the
    // tail index, so each register has a single always_ff driver.
    genvar gi;
    generate
        for (gi = 0; gi < SKID_SLOTS; gi++) begin : g_slot
            logic [DATA_W-1:0] data_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (push && (wr_idx_reg == 1'(gi))) begin
                    data_reg <= push_data;
                end
            end
        end
    endgenerate

    assign head_data = rd_idx_reg ? g_slot[1].data_reg : g_slot[0].data_reg;
    assign count     = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_reg <= 1'b0;
            rd_idx_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_idx_reg <= ~wr_idx_reg;
            end
            if (pop) begin
                rd_idx_reg <= ~rd_idx_reg;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// -----------------------------------------------------------------------------
// line_buf_ctrl
// Controller for a single-port synchronous memory used as a line buffer
// between the pixel input stage and the convolution window logic.  A start
// pulse fills len words from the input stream (len clamps to DEPTH), then the
// words are read back in address order and streamed out with valid/ready.
// The memory's one-cycle registered read latency is absorbed by a two-entry
// skid buffer (line_buf_skid).
//
// Optional build macro:
//   LINE_BUF_REPLAY_EN - adds a replay input; a replay pulse in IDLE drains the
//                        previously filled line again without refilling it.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   one-cycle pulse, begins a transfer (IDLE only)
//   replay         in   (LINE_BUF_REPLAY_EN only) re-drain the last line
//   len            in   ADDR_W+1 word count, sampled on start
//   in_valid       in   input word valid
//   in_data        in   input word
//   in_ready       out  high while filling
//   out_valid      out  output word valid (skid head occupied)
//   out_data       out  output word (skid head)
//   out_ready      in   downstream accept
//   busy           out  high in any state except IDLE
//   done           out  one-cycle pulse after the last output handshake
//   mem_write_en   out  memory write strobe
//   mem_read_en    out  memory read strobe
//   mem_addr       out  memory address
//   mem_write_data out  memory write word
//   mem_read_data  in   memory read word, valid the cycle after mem_read_en
// -----------------------------------------------------------------------------
module line_buf_ctrl
    import line_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH     // must not exceed 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef LINE_BUF_REPLAY_EN
    input  logic              replay,
`endif
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   xfer_cnt_reg;   // words written (FILL) or reads issued (DRAIN)
    logic [ADDR_W:0]   cnt_reg;        // clamped transfer length
    logic              inflight_reg;   // a read was issued last cycle
    logic              done_reg;
`ifdef LINE_BUF_REPLAY_EN
    logic              have_xfer_reg;  // a transfer has completed since reset
`endif

    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W:0]   xfer_inc;
    logic              xfer_last;
    logic              wr_fire;
    logic              rd_fire;
    logic              pop;
    logic [1:0]        skid_count;
    logic [DATA_W-1:0] skid_head;
    logic [2:0]        owed;           // words already owed to downstream after this cycle's pop

    // Pointers count modulo DEPTH, which need not be a power of two.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
    endfunction

    assign len_clamped = (len > DEPTH_CNT) ? DEPTH_CNT : len;
    assign xfer_inc    = xfer_cnt_reg + (ADDR_W + 1)'(1);
    assign xfer_last   = (xfer_inc == cnt_reg);

    assign in_ready  = (state_reg == FILL);
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign wr_fire   = in_ready && in_valid;
    assign out_valid = (skid_count != 2'd0);
    assign out_data  = skid_head;
    assign pop       = out_valid && out_ready;

    // A word being popped this cycle frees its slot in time for a read issued
    // now (that read lands two edges later), so it is credited immediately.
    // Without this credit the pipeline would stall every third cycle and never
    // reach one word per cycle.
    assign owed    = 3'(skid_count) + 3'(inflight_reg) - 3'(pop);
    assign rd_fire = (state_reg == DRAIN) && (owed < 3'(SKID_SLOTS));

    // Writes and reads happen in disjoint states, so the strobes are mutually
    // exclusive by construction.  Address/data idle at zero.
    always_comb begin
        mem_write_en   = wr_fire;
        mem_read_en    = rd_fire;
        mem_addr       = '0;
        mem_write_data = '0;
        if (wr_fire) begin
            mem_addr       = wr_ptr_reg;
            mem_write_data = in_data;
        end else if (rd_fire) begin
            mem_addr = rd_ptr_reg;
        end
    end

    line_buf_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_reg),
        .push_data (mem_read_data),
        .pop       (pop),
        .head_data (skid_head),
        .count     (skid_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            xfer_cnt_reg  <= '0;
            cnt_reg       <= '0;
            inflight_reg  <= 1'b0;
            done_reg      <= 1'b0;
`ifdef LINE_BUF_REPLAY_EN
            have_xfer_reg <= 1'b0;
`endif
        end else begin
            done_reg     <= 1'b0;
            inflight_reg <= rd_fire;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg    <= FILL;
                            wr_ptr_reg   <= '0;
                            xfer_cnt_reg <= '0;
                            cnt_reg      <= len_clamped;
                        end
`ifdef LINE_BUF_REPLAY_EN
                    end else if (replay) begin
                        // cnt_reg still holds the length of the last line.
                        if (have_xfer_reg) begin
                            state_reg    <= DRAIN;
                            rd_ptr_reg   <= '0;
                            xfer_cnt_reg <= '0;
                        end else begin
                            done_reg <= 1'b1;
                        end
`endif
                    end
                end

                FILL: begin
                    if (wr_fire) begin
                        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                        if (xfer_last) begin
                            // Reads may start on the very next cycle.
                            state_reg    <= DRAIN;
                            rd_ptr_reg   <= '0;
                            xfer_cnt_reg <= '0;
                        end else begin
                            xfer_cnt_reg <= xfer_inc;
                        end
                    end
                end

                DRAIN: begin
                    if (rd_fire) begin
                        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                        if (xfer_last) begin
                            state_reg <= FLUSH;
                        end else begin
                            xfer_cnt_reg <= xfer_inc;
                        end
                    end
                end

                FLUSH: begin
                    // Finish on the edge that accepts the last word, so done
                    // is high in the cycle right after that handshake.
                    if (!inflight_reg &&
                        ((skid_count == 2'd0) || ((skid_count == 2'd1) && pop))) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
`ifdef LINE_BUF_REPLAY_EN
                        have_xfer_reg <= 1'b1;
`endif
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
module tb_line_buf_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
`ifdef LINE_BUF_REPLAY_EN
    logic          replay;
`endif
    logic [AW:0]   len;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          mem_write_en;
    logic          mem_read_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;

    always #5 clk = ~clk;

    line_buf_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
`ifdef LINE_BUF_REPLAY_EN
        .replay         (replay),
`endif
        .len            (len),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Single-port memory with a registered read port.
    logic [DW-1:0] mem_arr [DEPTH];
    always @(posedge clk) begin
        if (mem_write_en) mem_arr[mem_addr] <= mem_write_data;
        if (mem_read_en)  mem_read_data <= mem_arr[mem_addr];
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model (transaction level) ----------------
    bit            m_busy      = 0;  // a transfer is in progress
    bit            m_done_next = 0;  // done must be high next cycle
    bit            m_have      = 0;  // a line has completed since reset
    int            m_cnt       = 0;  // words in the current line
    int            m_wr        = 0;  // words written so far
    int            m_rd        = 0;  // reads issued so far
    int            m_out       = 0;  // words delivered so far
    bit            prev_stall  = 0;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_words[$];     // the line, in arrival order
    logic [DW-1:0] outs[$];          // every delivered word (log)
    int            wr_log[$];        // every write address (log)
    int            rd_total    = 0;
    int            done_seen   = 0;
    bit            mode_full   = 1;  // out_ready held high

    always @(negedge clk) begin
        bit b0;
        bit exp_wr;
        if (rst) begin
            m_busy = 0; m_done_next = 0; m_have = 0; prev_stall = 0;
            m_cnt = 0; m_wr = 0; m_rd = 0; m_out = 0;
        end else begin
            b0     = m_busy;
            exp_wr = m_busy && (m_wr < m_cnt) && in_valid;

            chk("done", int'(done), int'(m_done_next));
            chk("busy", int'(busy), int'(m_busy));
            chk("in_ready", int'(in_ready), int'(m_busy && (m_wr < m_cnt)));
            chk("wr_en", int'(mem_write_en), int'(exp_wr));
            chk("excl", int'(mem_write_en && mem_read_en), 0);
            if (!(m_busy && (m_wr == m_cnt) && (m_rd < m_cnt)))
                chk("rd_en_idle", int'(mem_read_en), 0);
            if (!m_busy) chk("out_valid_idle", int'(out_valid), 0);
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(prev_data));
            end
            if (mode_full && m_busy && (m_out > 0) && (m_out < m_cnt))
                chk("throughput", int'(out_valid), 1);

            m_done_next = 0;
            if (exp_wr) begin
                chk("wr_addr", int'(mem_addr), m_wr % DEPTH);
                chk("wr_data", int'(mem_write_data), int'(in_data));
                exp_words.push_back(in_data);
                wr_log.push_back(int'(mem_addr));
                m_wr++;
            end
            if (mem_read_en) begin
                rd_total++;
                if (m_busy && (m_wr == m_cnt) && (m_rd < m_cnt)) begin
                    chk("rd_addr", int'(mem_addr), m_rd % DEPTH);
                    m_rd++;
                end
            end
            if (out_valid && out_ready && m_busy) begin
                if (m_out < exp_words.size())
                    chk("out_data", int'(out_data), int'(exp_words[m_out]));
                else
                    chk("out_extra", m_out, exp_words.size());
                $display("out word %0d = 0x%02h", m_out, out_data);
                outs.push_back(out_data);
                m_out++;
                if (m_out == m_cnt) begin
                    m_done_next = 1;
                    m_busy      = 0;
                    m_have      = 1;
                end
            end
            if (mem_read_en) chk("owed_le_2", int'((m_rd - m_out) <= 2), 1);
            if (done) done_seen++;

            if (!b0 && start) begin
                if (len == 0) m_done_next = 1;
                else begin
                    m_busy = 1;
                    m_cnt  = (int'(len) > DEPTH) ? DEPTH : int'(len);
                    m_wr = 0; m_rd = 0; m_out = 0;
                    exp_words.delete();
                end
            end
`ifdef LINE_BUF_REPLAY_EN
            else if (!b0 && replay) begin
                if (m_have) begin
                    m_busy = 1; m_rd = 0; m_out = 0;
                end else m_done_next = 1;
            end
`endif
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // out_ready driver: held high, or toggling every cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = mode_full ? 1'b1 : ~out_ready;
        end
    end

    // ---------------- stimulus helpers (enter/leave at posedge+1) ----------
    task automatic do_start(input int l);
        start = 1'b1; len = (AW + 1)'(l);
        @(posedge clk); #1;
        start = 1'b0; len = '0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int gap);
        bit r;
        bit ok;
        ok = 0;
        repeat (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
        in_valid = 1'b1; in_data = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1; break; end
        end
        if (!ok) chk("in_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound);
        int k;
        k = 0;
        while (done_seen == d0 && k < bound) begin @(posedge clk); #1; k++; end
        chk("done_timeout", int'(done_seen != d0), 1);
    endtask

    // ---------------- directed tests ----------------------------------------
    initial begin
        int base, wb, d0, rb;
        logic [DW-1:0] lit4 [4];
        lit4[0] = 8'hA1; lit4[1] = 8'hB2; lit4[2] = 8'hC3; lit4[3] = 8'hD4;

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
`ifdef LINE_BUF_REPLAY_EN
        replay = 1'b0;
`endif
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mem_we", int'(mem_write_en), 0);
        chk("rst_mem_re", int'(mem_read_en), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_out_data", int'(out_data), 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic fill/drain.
        base = outs.size(); wb = wr_log.size(); d0 = done_seen;
        do_start(4);
        for (int i = 0; i < 4; i++) send_word(lit4[i], 0);
        wait_done(d0, 100);
        chk("basic_count", outs.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (outs.size() > base + i) chk("basic_word", int'(outs[base + i]), int'(lit4[i]));
            if (wr_log.size() > wb + i) chk("basic_addr", wr_log[wb + i], i);
        end
        @(posedge clk); #1;
        chk("basic_busy_after", int'(busy), 0);

`ifdef LINE_BUF_REPLAY_EN
        // Replay the same line without refilling.
        base = outs.size(); wb = wr_log.size(); d0 = done_seen;
        replay = 1'b1; @(posedge clk); #1; replay = 1'b0;
        wait_done(d0, 100);
        chk("replay_count", outs.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (outs.size() > base + i) chk("replay_word", int'(outs[base + i]), int'(lit4[i]));
        chk("replay_no_writes", wr_log.size() - wb, 0);
        @(posedge clk); #1;
`endif

        // Backpressure: out_ready toggles every cycle.
        mode_full = 0;
        base = outs.size(); d0 = done_seen;
        do_start(8);
        for (int i = 0; i < 8; i++) send_word(8'(8'h10 + 8'(i * 7)), 0);
        wait_done(d0, 200);
        chk("bp_count", outs.size() - base, 8);
        for (int i = 0; i < 8; i++)
            if (outs.size() > base + i) chk("bp_word", int'(outs[base + i]), 16'h10 + i * 7);
        mode_full = 1;
        repeat (2) @(posedge clk); #1;

        // len = 0: done next cycle, no strobes.
        wb = wr_log.size(); rb = rd_total; d0 = done_seen;
        do_start(0);
        wait_done(d0, 3);
        chk("len0_writes", wr_log.size() - wb, 0);
        chk("len0_reads", rd_total - rb, 0);
        @(posedge clk); #1;

        // len = 31 clamps to 16.
        base = outs.size(); wb = wr_log.size(); d0 = done_seen;
        do_start(31);
        for (int i = 0; i < 16; i++) send_word(8'(8'hF0 - 8'(i)), 0);
        wait_done(d0, 200);
        chk("clamp_count", outs.size() - base, 16);
        chk("clamp_writes", wr_log.size() - wb, 16);
        if (wr_log.size() >= wb + 16) chk("clamp_last_addr", wr_log[wb + 15], 15);
        if (outs.size() >= base + 16) chk("clamp_last_word", int'(outs[base + 15]), 8'hE1);
        @(posedge clk); #1;

        // Input gaps: in_valid 1,0,0,1,1 with len = 3.
        base = outs.size(); wb = wr_log.size(); d0 = done_seen;
        do_start(3);
        send_word(8'h31, 0); send_word(8'h32, 2); send_word(8'h33, 0);
        wait_done(d0, 100);
        chk("gap_writes", wr_log.size() - wb, 3);
        for (int i = 0; i < 3; i++)
            if (wr_log.size() > wb + i) chk("gap_addr", wr_log[wb + i], i);
        @(posedge clk); #1;

        // Reset after 2 of 6 outputs, then a fresh len = 2 transfer.
        base = outs.size();
        do_start(6);
        for (int i = 0; i < 6; i++) send_word(8'(8'h40 + 8'(i)), 0);
        for (int k = 0; k < 100 && (outs.size() - base) < 2; k++) begin @(posedge clk); #1; end
        chk("rst_mid_reached", int'((outs.size() - base) >= 2), 1);
        rst = 1'b1; #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_mem_re", int'(mem_read_en), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        base = outs.size(); d0 = done_seen;
        do_start(2);
        send_word(8'h55, 0); send_word(8'h66, 0);
        wait_done(d0, 100);
        chk("post_rst_count", outs.size() - base, 2);
        if (outs.size() >= base + 2) begin
            chk("post_rst_w0", int'(outs[base]), 8'h55);
            chk("post_rst_w1", int'(outs[base + 1]), 8'h66);
        end
        repeat (2) @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
